// File: rtl/pipeline_ctrl_if.sv
// Datapath-facing bundle of pipeline_ctrl: hazard/redirect info in, stage enables and flushes out.
// The controller connects through the master modport, the datapath through slave.
interface pipeline_ctrl_if;
    logic [4:0] rs1_IF_ID;
    logic [4:0] rs2_IF_ID;
    logic [4:0] rd_ID_EXE;
    logic       mem_read_ID_EXE;
    logic       redirect;
    logic       en_pc;
    logic       en_IF_ID;
    logic       en_ID_EXE;
    logic       en_EXE_MEM;
    logic       en_MEM_WB;
    logic       flush_IF_ID;
    logic       flush_ID_EXE;

    modport master (
        input  rs1_IF_ID, rs2_IF_ID, rd_ID_EXE, mem_read_ID_EXE, redirect,
        output en_pc, en_IF_ID, en_ID_EXE, en_EXE_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EXE
    );

    modport slave (
        output rs1_IF_ID, rs2_IF_ID, rd_ID_EXE, mem_read_ID_EXE, redirect,
        input  en_pc, en_IF_ID, en_ID_EXE, en_EXE_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EXE
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencer for the 5-stage RISC-V pipeline: per-stage enables and bubbles, load-use stalls,
// wrong-path squashing after redirects, orderly drain on halt, and saturating perf counters.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned DRAIN_CYC = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic             halt_req,
    pipeline_ctrl_if.master  bus,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        FLUSH  = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYC - 1);
    localparam logic [3:0] DRAIN_RELOAD = 4'(DRAIN_CYC);

    state_t     state_q;
    logic [3:0] down_q;
    logic       lu;
    logic       en_pc, en_if_id, en_id_exe, en_exe_mem, en_mem_wb;
    logic       flush_if_id, flush_id_exe;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign lu = bus.mem_read_ID_EXE && (bus.rd_ID_EXE != 5'd0) &&
                ((bus.rd_ID_EXE == bus.rs1_IF_ID) || (bus.rd_ID_EXE == bus.rs2_IF_ID));

    always_comb begin
        en_pc        = 1'b0;
        en_if_id     = 1'b0;
        en_id_exe    = 1'b0;
        en_exe_mem   = 1'b0;
        en_mem_wb    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        case (state_q)
            RUN: begin
                en_pc        = bus.redirect || !lu;
                en_if_id     = bus.redirect || !lu;
                en_id_exe    = 1'b1;
                en_exe_mem   = 1'b1;
                en_mem_wb    = 1'b1;
                flush_if_id  = bus.redirect;
                flush_id_exe = bus.redirect || lu;
            end
            FLUSH: begin
                en_pc        = 1'b1;
                en_if_id     = 1'b1;
                en_id_exe    = 1'b1;
                en_exe_mem   = 1'b1;
                en_mem_wb    = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_exe = 1'b1;
            end
            // Fetch is frozen and IF_ID fills with NOPs so in-flight work retires cleanly.
            DRAIN: begin
                en_if_id     = !lu;
                en_id_exe    = 1'b1;
                en_exe_mem   = 1'b1;
                en_mem_wb    = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_exe = lu;
            end
            default: ;
        endcase
    end

    assign bus.en_pc        = en_pc;
    assign bus.en_IF_ID     = en_if_id;
    assign bus.en_ID_EXE    = en_id_exe;
    assign bus.en_EXE_MEM   = en_exe_mem;
    assign bus.en_MEM_WB    = en_mem_wb;
    assign bus.flush_IF_ID  = flush_if_id;
    assign bus.flush_ID_EXE = flush_id_exe;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            down_q       <= 4'd0;
            cycle_cnt    <= '0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    if (bus.redirect) begin
                        redirect_cnt <= sat_inc(redirect_cnt);
                        if (FLUSH_CYC > 1) begin
                            state_q <= FLUSH;
                            down_q  <= FLUSH_RELOAD;
                        end
                    end else if (lu) begin
                        stall_cnt <= sat_inc(stall_cnt);
                    end else if (halt_req) begin
                        state_q <= DRAIN;
                        down_q  <= DRAIN_RELOAD;
                    end
                end
                FLUSH: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    if (bus.redirect) begin
                        redirect_cnt <= sat_inc(redirect_cnt);
                        down_q       <= FLUSH_RELOAD;
                        if (FLUSH_CYC <= 1) state_q <= RUN;
                    end else if (down_q <= 4'd1) begin
                        state_q <= RUN;
                        down_q  <= 4'd0;
                    end else begin
                        down_q <= down_q - 4'd1;
                    end
                end
                DRAIN: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    if (lu) begin
                        stall_cnt <= sat_inc(stall_cnt);
                    end else if (down_q <= 4'd1) begin
                        state_q <= HALTED;
                        down_q  <= 4'd0;
                    end else begin
                        down_q <= down_q - 4'd1;
                    end
                end
                default: begin
                    // A fresh run starts with clean statistics.
                    if (start) begin
                        state_q      <= RUN;
                        down_q       <= 4'd0;
                        cycle_cnt    <= '0;
                        stall_cnt    <= '0;
                        redirect_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign state  = state_q;
    assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl with the default FLUSH_CYC=2, DRAIN_CYC=4, CNT_W=32.
// Inputs change 2 time units after each rising edge; outputs are sampled 1 unit later.
module tb_pipeline_ctrl;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic        halt_req;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] redirect_cnt;
    int          checks;
    int          errors;
    int          run_ticks;
    int          exp_cycles;

    pipeline_ctrl_if pif();

    pipeline_ctrl dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .start        (start),
        .halt_req     (halt_req),
        .bus          (pif.master),
        .state        (state),
        .halted       (halted),
        .cycle_cnt    (cycle_cnt),
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
    );

    wire [4:0] en_vec = {pif.en_pc, pif.en_IF_ID, pif.en_ID_EXE, pif.en_EXE_MEM, pif.en_MEM_WB};
    wire [1:0] fl_vec = {pif.flush_IF_ID, pif.flush_ID_EXE};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        start               = 1'b0;
        halt_req            = 1'b0;
        pif.rs1_IF_ID       = 5'd0;
        pif.rs2_IF_ID       = 5'd0;
        pif.rd_ID_EXE       = 5'd0;
        pif.mem_read_ID_EXE = 1'b0;
        pif.redirect        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        run_ticks++;
    endtask

    task automatic test_reset();
        clear_inputs();
        arst_n = 1'b0;
        #12;
        checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        checks++; if ({en_vec, fl_vec, halted} !== 8'b0) begin errors++; $display("[TB] FAIL reset_outputs: got %b expected 00000000", {en_vec, fl_vec, halted}); end
        checks++; if ({cycle_cnt, stall_cnt, redirect_cnt} !== 96'b0) begin errors++; $display("[TB] FAIL reset_counters: got %0h/%0h/%0h expected 0/0/0", cycle_cnt, stall_cnt, redirect_cnt); end
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_start();
        start = 1'b1;
        #1;
        checks++; if (en_vec !== 5'b00000) begin errors++; $display("[TB] FAIL idle_en: got %b expected 00000", en_vec); end
        tick();
        start = 1'b0;
        run_ticks = 0;
        #1;
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL start_state: got %0d expected 1", state); end
        checks++; if (en_vec !== 5'b11111 || fl_vec !== 2'b00) begin errors++; $display("[TB] FAIL start_en: got %b/%b expected 11111/00", en_vec, fl_vec); end
        for (int i = 0; i < 10; i++) tick();
        checks++; if (cycle_cnt !== 32'd10) begin errors++; $display("[TB] FAIL cycle_cnt_10: got %0d expected 10", cycle_cnt); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL stall_cnt_0: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_load_use();
        pif.mem_read_ID_EXE = 1'b1;
        pif.rd_ID_EXE       = 5'd5;
        pif.rs2_IF_ID       = 5'd5;
        #1;
        checks++; if (en_vec !== 5'b00111 || fl_vec !== 2'b01) begin errors++; $display("[TB] FAIL lu_rs2_ctrl: got %b/%b expected 00111/01", en_vec, fl_vec); end
        tick();
        clear_inputs();
        #1;
        checks++; if (en_vec !== 5'b11111 || fl_vec !== 2'b00) begin errors++; $display("[TB] FAIL lu_one_cycle: got %b/%b expected 11111/00", en_vec, fl_vec); end
        checks++; if (stall_cnt !== 32'd1 || state !== 3'd1) begin errors++; $display("[TB] FAIL lu_stall_cnt: got %0d st%0d expected 1 st1", stall_cnt, state); end
        // rd of x0 never creates a hazard
        pif.mem_read_ID_EXE = 1'b1;
        #1;
        checks++; if (en_vec !== 5'b11111 || fl_vec !== 2'b00) begin errors++; $display("[TB] FAIL lu_rd0: got %b/%b expected 11111/00", en_vec, fl_vec); end
        tick();
        pif.rd_ID_EXE = 5'd7;
        pif.rs1_IF_ID = 5'd7;
        pif.rs2_IF_ID = 5'd3;
        #1;
        checks++; if (en_vec !== 5'b00111 || fl_vec !== 2'b01) begin errors++; $display("[TB] FAIL lu_rs1_ctrl: got %b/%b expected 00111/01", en_vec, fl_vec); end
        tick();
        clear_inputs();
        #1;
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("[TB] FAIL lu_stall_cnt2: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_redirect();
        pif.redirect = 1'b1;
        #1;
        checks++; if (en_vec !== 5'b11111 || fl_vec !== 2'b11) begin errors++; $display("[TB] FAIL redir_run_ctrl: got %b/%b expected 11111/11", en_vec, fl_vec); end
        tick();
        pif.redirect = 1'b0;
        #1;
        checks++; if (state !== 3'd2 || fl_vec !== 2'b11 || en_vec !== 5'b11111) begin errors++; $display("[TB] FAIL redir_flush: got st%0d %b/%b expected st2 11111/11", state, en_vec, fl_vec); end
        checks++; if (redirect_cnt !== 32'd1) begin errors++; $display("[TB] FAIL redir_cnt1: got %0d expected 1", redirect_cnt); end
        tick();
        #1;
        checks++; if (state !== 3'd1 || fl_vec !== 2'b00) begin errors++; $display("[TB] FAIL redir_back_run: got st%0d fl%b expected st1 fl00", state, fl_vec); end
        // a redirect in FLUSH reloads the window, extending it by one cycle
        pif.redirect = 1'b1;
        tick();
        #1;
        checks++; if (state !== 3'd2 || fl_vec !== 2'b11) begin errors++; $display("[TB] FAIL redir_in_flush: got st%0d fl%b expected st2 fl11", state, fl_vec); end
        tick();
        pif.redirect        = 1'b0;
        pif.mem_read_ID_EXE = 1'b1;
        pif.rd_ID_EXE       = 5'd5;
        pif.rs2_IF_ID       = 5'd5;
        #1;
        checks++; if (state !== 3'd2 || en_vec !== 5'b11111 || fl_vec !== 2'b11) begin errors++; $display("[TB] FAIL flush_ext_lu_ignored: got st%0d %b/%b expected st2 11111/11", state, en_vec, fl_vec); end
        checks++; if (redirect_cnt !== 32'd3) begin errors++; $display("[TB] FAIL redir_cnt3: got %0d expected 3", redirect_cnt); end
        tick();
        clear_inputs();
        #1;
        checks++; if (state !== 3'd1 || fl_vec !== 2'b00 || stall_cnt !== 32'd2) begin errors++; $display("[TB] FAIL flush_end: got st%0d fl%b stall%0d expected st1 fl00 stall2", state, fl_vec, stall_cnt); end
    endtask

    task automatic test_redirect_vs_lu();
        pif.redirect        = 1'b1;
        pif.mem_read_ID_EXE = 1'b1;
        pif.rd_ID_EXE       = 5'd9;
        pif.rs1_IF_ID       = 5'd9;
        #1;
        checks++; if (en_vec !== 5'b11111 || fl_vec !== 2'b11) begin errors++; $display("[TB] FAIL redir_wins_ctrl: got %b/%b expected 11111/11", en_vec, fl_vec); end
        tick();
        clear_inputs();
        #1;
        checks++; if (stall_cnt !== 32'd2 || redirect_cnt !== 32'd4 || state !== 3'd2) begin errors++; $display("[TB] FAIL redir_wins_cnt: got stall%0d redir%0d st%0d expected stall2 redir4 st2", stall_cnt, redirect_cnt, state); end
        tick();
    endtask

    task automatic test_drain();
        halt_req = 1'b1;
        #1;
        checks++; if (state !== 3'd1 || en_vec !== 5'b11111 || fl_vec !== 2'b00) begin errors++; $display("[TB] FAIL halt_run_cycle: got st%0d %b/%b expected st1 11111/00", state, en_vec, fl_vec); end
        tick();
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state !== 3'd3 || en_vec !== 5'b01111 || fl_vec !== 2'b10) begin errors++; $display("[TB] FAIL drain_cycle%0d: got st%0d %b/%b expected st3 01111/10", i, state, en_vec, fl_vec); end
            tick();
        end
        exp_cycles = run_ticks;
        #1;
        checks++; if (state !== 3'd4 || halted !== 1'b1 || en_vec !== 5'b00000 || fl_vec !== 2'b00) begin errors++; $display("[TB] FAIL halted: got st%0d h%b %b/%b expected st4 h1 00000/00", state, halted, en_vec, fl_vec); end
        tick();
        tick();
        checks++; if (cycle_cnt !== 32'(exp_cycles)) begin errors++; $display("[TB] FAIL halted_cycle_cnt: got %0d expected %0d", cycle_cnt, exp_cycles); end
    endtask

    task automatic test_drain_lu();
        start    = 1'b1;
        halt_req = 1'b1;
        tick();
        start = 1'b0;
        #1;
        checks++; if (state !== 3'd1 || {cycle_cnt, stall_cnt, redirect_cnt} !== 96'b0) begin errors++; $display("[TB] FAIL restart_clear: got st%0d %0d/%0d/%0d expected st1 0/0/0", state, cycle_cnt, stall_cnt, redirect_cnt); end
        tick();
        halt_req            = 1'b0;
        pif.mem_read_ID_EXE = 1'b1;
        pif.rd_ID_EXE       = 5'd3;
        pif.rs1_IF_ID       = 5'd3;
        #1;
        checks++; if (state !== 3'd3 || en_vec !== 5'b00111 || fl_vec !== 2'b11) begin errors++; $display("[TB] FAIL drain_lu_ctrl: got st%0d %b/%b expected st3 00111/11", state, en_vec, fl_vec); end
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            start        = (i == 0);
            pif.redirect = (i == 1);
            #1;
            checks++; if (state !== 3'd3 || en_vec !== 5'b01111 || fl_vec !== 2'b10) begin errors++; $display("[TB] FAIL drain_lu_cycle%0d: got st%0d %b/%b expected st3 01111/10", i, state, en_vec, fl_vec); end
            tick();
        end
        clear_inputs();
        #1;
        checks++; if (state !== 3'd4 || stall_cnt !== 32'd1 || redirect_cnt !== 32'd0) begin errors++; $display("[TB] FAIL drain_lu_end: got st%0d stall%0d redir%0d expected st4 stall1 redir0", state, stall_cnt, redirect_cnt); end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        tick();
        start        = 1'b0;
        pif.redirect = 1'b1;
        tick();
        pif.redirect = 1'b0;
        #1;
        checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL pre_reset_flush: got st%0d expected st2", state); end
        #1;
        arst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || {en_vec, fl_vec, halted} !== 8'b0) begin errors++; $display("[TB] FAIL arst_outputs: got st%0d %b/%b h%b expected st0 00000/00 h0", state, en_vec, fl_vec, halted); end
        checks++; if ({cycle_cnt, stall_cnt, redirect_cnt} !== 96'b0) begin errors++; $display("[TB] FAIL arst_counters: got %0d/%0d/%0d expected 0/0/0", cycle_cnt, stall_cnt, redirect_cnt); end
        arst_n = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        #1;
        checks++; if (state !== 3'd1 || en_vec !== 5'b11111 || cycle_cnt !== 32'd0) begin errors++; $display("[TB] FAIL arst_restart: got st%0d %b cyc%0d expected st1 11111 cyc0", state, en_vec, cycle_cnt); end
        tick();
        checks++; if (cycle_cnt !== 32'd1) begin errors++; $display("[TB] FAIL arst_restart_cnt: got %0d expected 1", cycle_cnt); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        run_ticks = 0;
        test_reset();
        test_start();
        test_load_use();
        test_redirect();
        test_redirect_vs_lu();
        test_drain();
        test_drain_lu();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
